// File: rtl/br_pred_ctrl.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters, EX-stage mispredict detection.
// Optional performance counters are enabled by defining BR_STAT_EN.
module br_pred_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] PC_IF,
  output logic        Br_pred,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_PC,
  input  logic        ex_pred,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic [31:0] redirect_PC,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_reg  [DEPTH];
  logic [TAG_W-1:0] tag_reg    [DEPTH];
  logic [31:0]      target_reg [DEPTH];
  logic [1:0]       ctr_reg    [DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             res, mispredict;
  logic [31:0]      redir_next;
  logic             upd_en;
  logic [1:0]       upd_ctr;
  logic [31:0]      upd_target;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{PC_IF[1:0], ex_PC[1:0]};

  assign if_idx = PC_IF[IDX_W+1:2];
  assign if_tag = PC_IF[31:IDX_W+2];
  assign ex_idx = ex_PC[IDX_W+1:2];
  assign ex_tag = ex_PC[31:IDX_W+2];

  assign if_hit      = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign Br_pred     = if_hit && ctr_reg[if_idx][1];
  assign pred_target = Br_pred ? target_reg[if_idx] : PC_IF + 32'd4;

  assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);
  assign res    = ex_valid && ex_is_br && !stall;

  always_comb begin
    mispredict = 1'b0;
    redir_next = 32'd0;
    if (ex_pred && !ex_taken) begin
      mispredict = 1'b1;
      redir_next = ex_PC + 32'd4;
    end else if (!ex_pred && ex_taken) begin
      mispredict = 1'b1;
      redir_next = ex_target;
    end else if (ex_pred && ex_taken && (target_reg[ex_idx] != ex_target)) begin
      mispredict = 1'b1;
      redir_next = ex_target;
    end
  end

  assign flush       = res && mispredict;
  assign redirect_PC = flush ? redir_next : 32'd0;

  // A not-taken branch that misses the table leaves it untouched.
  always_comb begin
    upd_en     = res && (ex_taken || ex_hit);
    upd_ctr    = ctr_reg[ex_idx];
    upd_target = target_reg[ex_idx];
    if (ex_taken) begin
      upd_target = ex_target;
      if (!ex_hit)
        upd_ctr = 2'b10;
      else if (ctr_reg[ex_idx] != 2'b11)
        upd_ctr = ctr_reg[ex_idx] + 2'd1;
    end else if (ctr_reg[ex_idx] != 2'b00) begin
      upd_ctr = ctr_reg[ex_idx] - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi]  <= 1'b0;
          tag_reg[gi]    <= '0;
          target_reg[gi] <= 32'd0;
          ctr_reg[gi]    <= 2'b01;
        end else if (upd_en && (ex_idx == IDX_W'(gi))) begin
          valid_reg[gi]  <= 1'b1;
          tag_reg[gi]    <= ex_tag;
          target_reg[gi] <= upd_target;
          ctr_reg[gi]    <= upd_ctr;
        end
      end
    end
  endgenerate

`ifdef BR_STAT_EN
  logic [31:0] br_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_reg   <= 32'd0;
      miss_cnt_reg <= 32'd0;
    end else begin
      if (res)
        br_cnt_reg <= br_cnt_reg + 32'd1;
      if (flush)
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign br_cnt   = br_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign br_cnt   = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed bench for br_pred_ctrl (IDX_W=3); 0x40 and 0x60 alias to index 0.
module tb_br_pred_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] PC_IF;
  logic        Br_pred;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_br, ex_pred, ex_taken;
  logic [31:0] ex_PC, ex_target;
  logic        flush;
  logic [31:0] redirect_PC, br_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  br_pred_ctrl #(.IDX_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PC_IF(PC_IF),
    .Br_pred(Br_pred), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_PC(ex_PC),
    .ex_pred(ex_pred), .ex_taken(ex_taken), .ex_target(ex_target),
    .flush(flush), .redirect_PC(redirect_PC),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

`ifdef BR_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", tag, act);
    end
  endtask

  // Inputs change just after the falling edge; the rising edge in between commits updates.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic pred, input logic taken,
                         input logic [31:0] tgt);
    ex_valid = 1'b1; ex_is_br = 1'b1; ex_PC = pc;
    ex_pred = pred; ex_taken = taken; ex_target = tgt;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_is_br = 1'b0; ex_PC = 32'd0;
    ex_pred = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PC_IF = 32'h40;
    idle_ex();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_br_pred", 32'(Br_pred), 32'd0);
    check("rst_pred_target", pred_target, 32'h44);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", redirect_PC, 32'd0);
    check("rst_br_cnt", br_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);

    // Allocate 0x40 -> 0x100; same-cycle lookup still sees the old entry.
    tick(); resolve(32'h40, 1'b0, 1'b1, 32'h100); #1;
    check("alloc_flush", 32'(flush), 32'd1);
    check("alloc_redirect", redirect_PC, 32'h100);
    check("alloc_rbw_pred", 32'(Br_pred), 32'd0);
    tick(); idle_ex(); #1;
    check("after_alloc_pred", 32'(Br_pred), 32'd1);
    check("after_alloc_target", pred_target, 32'h100);
    check("idle_flush", 32'(flush), 32'd0);

    // Predicted taken, resolved not taken: ctr 10 -> 01.
    tick(); resolve(32'h40, 1'b1, 1'b0, 32'h100); #1;
    check("nt_flush", 32'(flush), 32'd1);
    check("nt_redirect", redirect_PC, 32'h44);
    tick(); idle_ex(); #1;
    check("after_nt_pred", 32'(Br_pred), 32'd0);
    check("after_nt_target", pred_target, 32'h44);

    // Taken again: ctr 01 -> 10.
    tick(); resolve(32'h40, 1'b0, 1'b1, 32'h100); #1;
    check("retaken_redirect", redirect_PC, 32'h100);
    tick(); idle_ex(); #1;
    check("retaken_pred", 32'(Br_pred), 32'd1);

    // Predicted taken, target changed: ctr 10 -> 11, target 0x200.
    tick(); resolve(32'h40, 1'b1, 1'b1, 32'h200); #1;
    check("tgt_flush", 32'(flush), 32'd1);
    check("tgt_redirect", redirect_PC, 32'h200);
    tick(); idle_ex(); #1;
    check("tgt_lookup", pred_target, 32'h200);

    // Correct prediction: no flush, redirect stays 0.
    tick(); resolve(32'h40, 1'b1, 1'b1, 32'h200); #1;
    check("hit_flush", 32'(flush), 32'd0);
    check("hit_redirect", redirect_PC, 32'd0);

    // Non-branch with mismatching fields must do nothing.
    tick(); resolve(32'h40, 1'b1, 1'b0, 32'h0); ex_is_br = 1'b0; #1;
    check("nonbr_flush", 32'(flush), 32'd0);
    tick(); idle_ex(); #1;
    check("nonbr_pred", 32'(Br_pred), 32'd1);

    // Alias 0x60 replaces entry 0.
    tick(); resolve(32'h60, 1'b0, 1'b1, 32'h300); #1;
    check("alias_redirect", redirect_PC, 32'h300);
    tick(); idle_ex(); #1;
    check("alias_old_pred", 32'(Br_pred), 32'd0);
    check("alias_old_target", pred_target, 32'h44);
    PC_IF = 32'h60; #1;
    check("alias_new_pred", 32'(Br_pred), 32'd1);
    check("alias_new_target", pred_target, 32'h300);

    // Stall with a mispredict in EX for 3 cycles.
    tick(); stall = 1'b1; resolve(32'h60, 1'b1, 1'b0, 32'h300);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_flush", i), 32'(flush), 32'd0);
      check($sformatf("stall%0d_redirect", i), redirect_PC, 32'd0);
      check($sformatf("stall%0d_pred", i), 32'(Br_pred), 32'd1);
      tick();
    end
    stall = 1'b0; #1;
    check("unstall_flush", 32'(flush), 32'd1);
    check("unstall_redirect", redirect_PC, 32'h64);
    tick(); idle_ex(); #1;
    check("unstall_once", 32'(flush), 32'd0);
    check("unstall_pred", 32'(Br_pred), 32'd0);

    // PC+4 wraps at 2^32.
    PC_IF = 32'hFFFF_FFFC; #1;
    check("wrap_target", pred_target, 32'h0);

    // 7 resolved branches, 6 of them mispredicted.
    check("stat_br_cnt", br_cnt, STAT ? 32'd7 : 32'd0);
    check("stat_miss_cnt", miss_cnt, STAT ? 32'd6 : 32'd0);

    // Reset dominates a same-cycle update.
    tick(); rst = 1'b1; resolve(32'h80, 1'b0, 1'b1, 32'h400);
    tick(); rst = 1'b0; idle_ex(); PC_IF = 32'h60; #1;
    check("rst2_pred_60", 32'(Br_pred), 32'd0);
    check("rst2_br_cnt", br_cnt, 32'd0);
    check("rst2_miss_cnt", miss_cnt, 32'd0);
    PC_IF = 32'h80; #1;
    check("rst2_pred_80", 32'(Br_pred), 32'd0);
    check("rst2_target_80", pred_target, 32'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
